// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory sequencer/arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [5:0] LOAD_OPC_DEF = 6'b000100;
  localparam logic [5:0] NOP_OPC_DEF  = 6'b000000;
  localparam int         DEPTH_DEF    = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: the port that did not win last time has priority
// when both request. Purely combinational; the history flop lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       winner
);

  // Choose the winner and produce a one-hot grant
  always_comb begin
    grant  = 2'b00;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = 1'b1;
    end
    if (req != 2'b00) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer and two-port round-robin arbiter in front of a single-port data
// memory with a registered read port. One access in flight at a time; every
// accepted request ends in exactly one done pulse on the owning port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter int         AW       = 32,
  parameter int         DW       = 32,
  parameter logic [5:0] LOAD_OPC = LOAD_OPC_DEF,
  parameter logic [5:0] NOP_OPC  = NOP_OPC_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [5:0]    mem_opc,
  output logic          mem_wea,
  input  logic [DW-1:0] mem_rdata
);

  // Full-width bound so high address bits can never alias into the array.
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          idle;
  logic [1:0]    arb_req;
  logic [1:0]    grant;
  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          resp;

  // Grants are only offered in IDLE and never while reset is being applied,
  // otherwise a requester could see gnt for a request the FSM discards.
  assign idle    = (state_q == ST_IDLE) && reset_n;
  assign arb_req = {m1_req, m0_req} & {2{idle}};

  rr_arb2 u_rr_arb2 (
    .req        (arb_req),
    .last_owner (last_owner_q),
    .grant      (grant),
    .winner     (winner)
  );

  assign sel_we    = winner ? m1_we    : m0_we;
  assign sel_addr  = winner ? m1_addr  : m0_addr;
  assign sel_wdata = winner ? m1_wdata : m0_wdata;

  assign resp      = (state_q == ST_RESP);
  assign m0_gnt    = grant[0];
  assign m1_gnt    = grant[1];
  assign m0_done   = resp && !owner_q;
  assign m1_done   = resp && owner_q;
  assign m0_err    = m0_done && err_q;
  assign m1_err    = m1_done && err_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

  // Memory pins: latched address/data always presented, strobes only in ACCESS
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wea   = (state_q == ST_ACCESS) && we_q;
  assign mem_opc   = ((state_q == ST_ACCESS) && !we_q) ? LOAD_OPC : NOP_OPC;

  // Next-state: latch winning request, sequence access, capture load data
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = (sel_addr >= DEPTH_A);
          // A new transaction's rdata reads 0 unless a load fills it later.
          if (winner) rdata1_d = '0;
          else        rdata0_d = '0;
          state_d      = (sel_addr >= DEPTH_A) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (owner_q) rdata1_d = mem_rdata;
        else         rdata0_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset aborts any in-flight access
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and two-port arbiter in front of the single-port 8-word data memory (`DataMemory`). Two requesters share that memory through one round-robin arbiter: port 0 is the CPU load/store stage and port 1 is the debug/loader port. The block drives the memory's `addressin`, `datain`, `OPC` and `WEA` pins, and it captures the memory's registered `dataout` to return read data. One access is in flight at a time, and every accepted request ends with exactly one `done` pulse on the owning port.

## Interface
Parameters:
- `DEPTH`, 8: number of memory words. Addresses at or above this value are errors.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LOAD_OPC`, 6'b000100: opcode presented on `mem_opc` during a read access.
- `NOP_OPC`, 6'b000000: opcode presented on `mem_opc` at all other times.

Ports (a `mN_` prefix means the port exists for N=0 and for N=1):
- `clock`  in  1: the single clock. All logic is sampled on the rising edge.
- `reset_n`  in  1: synchronous reset, active-low.
- `mN_req`  in  1: request valid.
- `mN_we`  in  1: 1 = store, 0 = load.
- `mN_addr`  in  AW: word address.
- `mN_wdata`  in  DW: store data.
- `mN_gnt`  out  1: request accepted this cycle.
- `mN_done`  out  1: one-cycle completion pulse.
- `mN_err`  out  1: qualifies `done`. Set when the address was out of range.
- `mN_rdata`  out  DW: load data, valid while `done`=1 for a load.
- `mem_addr`  out  AW: drives the memory `addressin` pin.
- `mem_wdata`  out  DW: drives the memory `datain` pin.
- `mem_opc`  out  6: drives the memory `OPC` pin.
- `mem_wea`  out  1: drives the memory `WEA` pin.
- `mem_rdata`  in  DW: the memory `dataout`, registered inside the memory.

## Operation
The block is a four-state FSM: IDLE, ACCESS, CAPTURE, RESP.

IDLE:
- If any `req` is high, pick a winner, assert that port's `gnt` combinationally for this cycle, and latch its `we`, `addr` and `wdata` plus the owner ID.
- Next state is ACCESS if `addr < DEPTH`. Otherwise next state is RESP with the error flag set.

ACCESS:
- `mem_addr` and `mem_wdata` come from the latched request.
- Store: `mem_wea`=1 and `mem_opc`=NOP. Next state is RESP.
- Load: `mem_wea`=0 and `mem_opc`=LOAD_OPC. Next state is CAPTURE.

CAPTURE:
- `mem_rdata` is valid in this cycle. Register it into the owner's `rdata`.
- Next state is RESP.

RESP:
- The owner's `done`=1 and `err`=the latched error flag.
- `rdata` holds the captured word. It holds 0 after an error or a store.
- Next state is IDLE.

Arbitration:
- Round-robin on a `last_owner` register, which resets to 1 so port 0 wins first.
- When both ports request, the port that is not `last_owner` wins.
- `last_owner` updates on every grant.

Handshake rules:
- Requesters hold `req`, `we`, `addr` and `wdata` stable until `gnt`.
- Dropping `req` before `gnt` withdraws the request without side effects.
- `req` held high after `gnt` is treated as a new request, which is considered in the IDLE cycle after RESP.
- `gnt` is never asserted outside IDLE.

Memory pins outside ACCESS:
- `mem_wea`=0 and `mem_opc`=NOP_OPC.
- `mem_addr` and `mem_wdata` hold the latched values.

An error request never touches the memory: no ACCESS cycle and no `wea` pulse.

Address handling: addresses are compared at full AW width, and only `addr` values below DEPTH reach the memory.

## Timing
Per-access timeline, with the grant in cycle 0:
- Store: `mem_wea` is high in cycle 1, and `done` pulses in cycle 2.
- Load: `mem_opc`=LOAD in cycle 1, `mem_rdata` is valid in cycle 2, and `done`/`rdata` appear in cycle 3.
- Error: `done`+`err` pulse in cycle 1.

Throughput:
- The earliest next grant is the cycle after RESP.
- Back-to-back throughput is therefore 1 store per 3 cycles and 1 load per 4 cycles.

Reset (`reset_n`=0 at a rising edge):
- The FSM returns to IDLE and `last_owner` is set to 1.
- All outputs go to 0, except `mem_opc`, which goes to NOP_OPC.
- An in-flight access is aborted and produces no `done`.
- A store whose ACCESS cycle coincides with the reset edge is still committed by the memory, because `wea` was high during that cycle.

Other cycle-level rules:
- `done` for the old owner and `gnt` for a new request never coincide.
- `done`, `err` and `gnt` are one cycle wide.

## Structure
Shared package `dmem_arb_pkg` holds:
- the state enum (IDLE, ACCESS, CAPTURE, RESP);
- `LOAD_OPC` and `NOP_OPC`;
- the `DEPTH` default.

Sub-module `rr_arb2`:
- Inputs: `req[1:0]` and `last_owner`.
- Outputs: one-hot `grant[1:0]` and `winner`.
- It is purely combinational. The `last_owner` flop lives in `dmem_arbiter`.

## Test plan
1. Reset followed by a port 0 load from addr 3: `gnt` in cycle 0, `mem_opc`=000100 in cycle 1, and `m0_done`=1 with `m0_rdata`=4 in cycle 3 (memory initial contents are word i = i+1 for i<7).
2. Port 1 stores 0xDEADBEEF to addr 5, then port 1 loads addr 5: `mem_wea`=1 for exactly 1 cycle with `mem_addr`=5, `m1_done` 2 cycles after the store grant, and the load returns 0xDEADBEEF.
3. Both ports request loads continuously from reset: grants alternate 0,1,0,1, with a `done` every 4 cycles on the matching port and never two grants within 4 cycles.
4. Port 0 loads addr 8: `m0_done`=1 and `m0_err`=1 in cycle 1, `mem_wea` stays 0 and `mem_opc` stays NOP throughout, and the next grant is possible in cycle 2.
5. `reset_n` driven low during CAPTURE of a port 0 load: no `m0_done` ever appears, the block is back in IDLE with all outputs 0, and the next simultaneous request is won by port 0.
6. `m1_req` pulsed for 1 cycle while port 0 is mid-access: no `m1_gnt`, no memory activity for port 1, and port 0's `done` arrives at its nominal cycle.
